// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul driver and the systolic array it feeds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matmul_pkg;

  localparam int WORD_W  = 40;  // one stream word = five signed bytes
  localparam int BYTE_W  = 8;
  localparam int GAP_LEN = 2;   // zero cycles separating weight/input phases

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_SEND_W  = 3'd2,
    S_GAP_W   = 3'd3,
    S_SEND_I  = 3'd4,
    S_GAP_I   = 3'd5,
    S_COLLECT = 3'd6,
    S_DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/matmul_driver.sv
// Host-side sequencer for the matmul array: buffers weights/inputs, streams them, collects results.
// Latency: first weight word 2 cycles after START, first input word N+2 cycles after that.
// Backpressure: none; the array is fire-and-forget, results time out after TMO cycles.
module matmul_driver
  import matmul_pkg::*;
#(
  parameter int N   = 5,
  parameter int T   = 10,
  parameter int TMO = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic              WR_SEL,
  input  logic [3:0]        WR_ADDR,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic              START,
  output logic              BUSY_o,
  output logic              DONE_o,
  output logic              ERR_o,
  output logic              OVF_o,
  output logic [WORD_W-1:0] Weight_o,
  output logic [WORD_W-1:0] In_o,
  input  logic [WORD_W-1:0] OUT_i,
  input  logic              VAL_i,
  input  logic              OV_i,
  input  logic [3:0]        RD_ADDR,
  output logic [WORD_W-1:0] RD_DATA
);

  localparam int TW = $clog2(TMO + 1);

  word_t        r_w [N];
  word_t        r_x [T];
  word_t        r_r [T];

  state_t       r_state;
  logic [3:0]   r_idx;
  logic [3:0]   r_cnt;
  logic [1:0]   r_gap;
  logic [TW-1:0] r_tmo;
  word_t        r_weight;
  word_t        r_in;
  logic         r_done;
  logic         r_err;
  logic         r_ovf;

  word_t        w_w_cur;
  word_t        w_x_cur;
  word_t        w_rd;
  logic         w_any_zero;
  logic         w_r_we;

  assign BUSY_o   = (r_state != S_IDLE);
  assign DONE_o   = r_done;
  assign ERR_o    = r_err;
  assign OVF_o    = r_ovf;
  assign Weight_o = r_weight;
  assign In_o     = r_in;
  assign RD_DATA  = w_rd;

  // The counter never exceeds T-1 while in COLLECT, so every accepted word has a slot.
  assign w_r_we = (r_state == S_COLLECT) && VAL_i;

  // Word-select muxes, terminator scan and result read port, all decoded against legal indices only.
  always_comb begin
    w_w_cur    = '0;
    w_x_cur    = '0;
    w_rd       = '0;
    w_any_zero = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == 4'(k)) w_w_cur = r_w[k];
      if (r_w[k] == '0)   w_any_zero = 1'b1;
    end
    for (int k = 0; k < T; k++) begin
      if (r_idx == 4'(k))   w_x_cur = r_x[k];
      if (r_x[k] == '0)     w_any_zero = 1'b1;
      if (RD_ADDR == 4'(k)) w_rd = r_r[k];
    end
  end

  // Host writes into the weight/input buffers; out-of-range addresses and writes during a job fall through.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N; k++) r_w[k] <= '0;
      for (int k = 0; k < T; k++) r_x[k] <= '0;
    end else if (WR_EN && !BUSY_o) begin
      for (int k = 0; k < N; k++)
        if (!WR_SEL && WR_ADDR == 4'(k)) r_w[k] <= WR_DATA;
      for (int k = 0; k < T; k++)
        if (WR_SEL && WR_ADDR == 4'(k)) r_x[k] <= WR_DATA;
    end
  end

  // Result capture, indexed by the running result count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < T; k++) r_r[k] <= '0;
    end else if (w_r_we) begin
      for (int k = 0; k < T; k++)
        if (r_cnt == 4'(k)) r_r[k] <= OUT_i;
    end
  end

  // Job sequencer; stream outputs are loaded on the transition into their state so they line up with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_tmo    <= '0;
      r_weight <= '0;
      r_in     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A zero word would read as an early terminator to the array, so refuse the job.
          if (w_any_zero) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_weight <= r_w[0];
            r_idx    <= 4'd1;
            r_state  <= S_SEND_W;
          end
        end
        S_SEND_W: begin
          if (r_idx == 4'(N)) begin
            r_weight <= '0;
            r_gap    <= '0;
            r_state  <= S_GAP_W;
          end else begin
            r_weight <= w_w_cur;
            r_idx    <= r_idx + 4'd1;
          end
        end
        S_GAP_W: begin
          if (r_gap == 2'(GAP_LEN - 1)) begin
            r_in    <= r_x[0];
            r_idx   <= 4'd1;
            r_state <= S_SEND_I;
          end else begin
            r_gap <= r_gap + 2'd1;
          end
        end
        S_SEND_I: begin
          if (r_idx == 4'(T)) begin
            r_in    <= '0;
            r_gap   <= '0;
            r_state <= S_GAP_I;
          end else begin
            r_in  <= w_x_cur;
            r_idx <= r_idx + 4'd1;
          end
        end
        S_GAP_I: begin
          if (r_gap == 2'(GAP_LEN - 1)) begin
            r_tmo   <= '0;
            r_state <= S_COLLECT;
          end else begin
            r_gap <= r_gap + 2'd1;
          end
        end
        S_COLLECT: begin
          r_ovf <= r_ovf | OV_i;
          if (VAL_i) r_cnt <= r_cnt + 4'd1;
          // A last word landing on the timeout cycle still counts as a clean finish.
          if (VAL_i && r_cnt == 4'(T - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_tmo == TW'(TMO - 1)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_driver.md
MATMUL_DRIVER -- requirements
Module: matmul_driver

Interface
REQ-001 SHALL have parameter N, default 5, meaning weight words (rows) sent per job, range 1..5.
REQ-002 SHALL have parameter T, default 10, meaning input words (time steps) sent and result words collected per job, range 1..15.
REQ-003 SHALL have parameter TMO, default 64, meaning the maximum cycles to wait for the last result word.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports CLK (input, 1, rising-edge clock) and RST (input, 1, async active-high reset).
REQ-005 SHALL have host write ports: WR_EN input 1 (write strobe); WR_SEL input 1 (0 = weight buffer, 1 = input buffer); WR_ADDR input 4 (word index); WR_DATA input 40 (five signed bytes, byte at bits 39:32 first).
REQ-006 SHALL have START input 1 (single-cycle job request), BUSY_o output 1 (job in progress) and DONE_o output 1 (single-cycle job-complete pulse).
REQ-007 SHALL have ERR_o output 1 (sticky error, cleared by START) and OVF_o output 1 (sticky OR of OV_i over a job, cleared by START).
REQ-008 SHALL have array-side ports: Weight_o output 40 (weight word stream); In_o output 40 (input word stream); OUT_i input 40 (result word); VAL_i input 1 (result valid); OV_i input 1 (overflow flag).
REQ-009 SHALL have result read ports: RD_ADDR input 4 (result index) and RD_DATA output 40 (result word, combinational read).

Function
REQ-010 SHALL hold weight buffer W[0..N-1] and input buffer X[0..T-1], 40 bits each, written on WR_EN when not BUSY_o; a write with WR_ADDR >= N (weights) or >= T (inputs) SHALL be dropped; a write while BUSY_o SHALL be dropped.
REQ-011 SHALL implement states IDLE, CHECK, SEND_W, GAP_W, SEND_I, GAP_I, COLLECT, DONE.
REQ-012 IDLE: on START, clear ERR_o, OVF_o and the result count, then go to CHECK; START while BUSY_o SHALL be ignored.
REQ-013 CHECK (1 cycle): if any W[k] or X[k] in range equals zero (a zero word is the stream terminator), set ERR_o and go to DONE without driving any nonzero word; otherwise go to SEND_W.
REQ-014 SEND_W: drive Weight_o = W[0..N-1], one word per cycle in order, In_o = 0.
REQ-015 GAP_W: drive Weight_o = 0 and In_o = 0 for exactly 2 cycles.
REQ-016 SEND_I: drive In_o = X[0..T-1], one word per cycle, Weight_o = 0.
REQ-017 GAP_I: drive In_o = 0 for exactly 2 cycles, then enter COLLECT with the timeout counter cleared.
REQ-018 COLLECT: on each cycle with VAL_i = 1, store OUT_i in R[count] and increment count; after T words go to DONE; VAL_i beyond T words SHALL be ignored.
REQ-019 COLLECT: OVF_o |= OV_i on every cycle; if TMO cycles elapse with count < T, set ERR_o and go to DONE; R entries not received retain their old values.
REQ-020 DONE: assert DONE_o for one cycle, then return to IDLE.
REQ-021 BUSY_o SHALL be 1 in every state except IDLE; Weight_o and In_o SHALL be 0 outside SEND_W and SEND_I.
REQ-022 Latency: first nonzero Weight_o SHALL appear 2 cycles after the START cycle; first In_o word SHALL appear N+2 cycles after the first weight word.
REQ-023 RD_DATA = R[RD_ADDR]; RD_ADDR >= T SHALL return 0; reads during BUSY_o return current contents.
REQ-024 VAL_i in any state other than COLLECT SHALL be ignored.

Reset
REQ-025 RST SHALL asynchronously force IDLE, BUSY_o=0, DONE_o=0, ERR_o=0, OVF_o=0, Weight_o=0, In_o=0, result count=0 and timeout=0, including mid-job.
REQ-026 RST SHALL clear W, X and R to zero.

Structure
REQ-027 State encodings, GAP length (2) and the 40-bit word / 8-bit byte widths SHALL be defined in shared package matmul_pkg, used also by the array.
REQ-028 SHALL be a single module with no sub-modules; the buffers SHALL be flop arrays.

Verification
REQ-029 Load W = 0x0102030405 x5 and X = 0x0101010101 x10, then START -> Weight_o carries 5 words then 2 zero cycles, In_o carries 10 words then 2 zero cycles; after 10 VAL_i cycles DONE_o pulses once, ERR_o=0.
REQ-030 Connect the driver to the matmul array with the same data -> every R[t] = 0x0F0F0F0F0F (1+2+3+4+5 = 15 per byte), OVF_o=0.
REQ-031 Set X[3]=0, then START -> ERR_o=1 and DONE_o pulse 2 cycles after START; Weight_o and In_o remain 0 throughout.
REQ-032 Send all words, then hold VAL_i=0 -> ERR_o=1 and DONE_o exactly TMO cycles after COLLECT entry.
REQ-033 Assert OV_i for one cycle during COLLECT -> OVF_o=1 until next START; a START pulse and a WR_EN write during SEND_I -> both ignored, buffer unchanged.
REQ-034 Assert RST during SEND_I -> Weight_o, In_o, BUSY_o = 0 immediately; the next START runs a full clean job.
